// File: rtl/axis_burst_scheduler_pkg.sv
// Shared types and defaults for the AXI4-Stream burst scheduler.
package axis_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_BURST_LEN = 8;

  // Successor of a requester index, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/axis_burst_scheduler_if.sv
// AXI4-Stream channel bundle between the scheduler and its downstream slave.
interface axis_burst_scheduler_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_burst_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] gnt_oh,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  // Scan offsets from farthest to nearest so the nearest asserted request wins.
  always_comb begin : pick
    int cand;
    cand      = 0;
    gnt_oh    = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = int'(rr_ptr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (req[cand]) begin
        gnt_oh       = '0;
        gnt_oh[cand] = 1'b1;
        gnt_idx      = PTR_W'(cand);
        gnt_valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_burst_scheduler.sv
// Shares one AXI4-Stream master among N_REQ requesters, one fixed-length burst at a time.
module axis_burst_scheduler
  import axis_sched_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int IDX_W     = $clog2(BURST_LEN) + 1
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [N_REQ-1:0]        req,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        done,
  output logic [IDX_W-1:0]        rd_index,
  input  logic [N_REQ*DATA_W-1:0] rd_data,
  axis_burst_scheduler_if.master  m_axis,
  output logic                    busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

  state_t             state_reg, state_next;
  logic [1:0]         rst_sync_reg;
  logic               rst_n_int;
  logic [N_REQ-1:0]   grant_reg;
  logic [PTR_W-1:0]   owner_reg;
  logic [PTR_W-1:0]   rr_ptr_reg;
  logic [IDX_W-1:0]   rd_index_reg;
  logic [N_REQ-1:0]   arb_oh;
  logic [PTR_W-1:0]   arb_idx;
  logic               arb_valid;
  logic               tvalid_int;
  logic               tlast_int;
  logic               last_beat;
  logic               handshake;
  logic [DATA_W-1:0]  slice [N_REQ];

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rst_sync_reg <= 2'b00;
    else          rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_n_int = rst_sync_reg[1];

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req       (req),
    .rr_ptr    (rr_ptr_reg),
    .gnt_oh    (arb_oh),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign slice[gi] = rd_data[gi*DATA_W +: DATA_W];
  end

  assign last_beat = (rd_index_reg == LAST_IDX);
  assign handshake = tvalid_int && m_axis.tready;

  // State register.
  always_ff @(posedge aclk or negedge rst_n_int) begin
    if (!rst_n_int) state_reg <= ST_IDLE;
    else            state_reg <= state_next;
  end

  // Next-state: start on any request, finish on the last accepted beat, DONE lasts one cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (arb_valid) state_next = ST_STREAM;
      ST_STREAM: if (handshake && last_beat) state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from the state; grant and done share the latched winner.
  always_comb begin
    grant      = '0;
    done       = '0;
    busy       = 1'b0;
    tvalid_int = 1'b0;
    tlast_int  = 1'b0;
    case (state_reg)
      ST_STREAM: begin
        grant      = grant_reg;
        busy       = 1'b1;
        tvalid_int = 1'b1;
        tlast_int  = last_beat;
      end
      ST_DONE: begin
        done = grant_reg;
        busy = 1'b1;
      end
      default: ;
    endcase
  end

  // Winner latch, beat counter and round-robin pointer.
  always_ff @(posedge aclk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      grant_reg    <= '0;
      owner_reg    <= '0;
      rr_ptr_reg   <= '0;
      rd_index_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (arb_valid) begin
            grant_reg    <= arb_oh;
            owner_reg    <= arb_idx;
            rd_index_reg <= '0;
          end
        end
        ST_STREAM: begin
          if (handshake) rd_index_reg <= rd_index_reg + IDX_W'(1);
        end
        ST_DONE: begin
          rr_ptr_reg <= PTR_W'(rr_next(int'(owner_reg), N_REQ));
        end
        default: ;
      endcase
    end
  end

  // Data comes straight from the owner's buffer; the owner holds it stable while granted.
  assign m_axis.tdata  = slice[owner_reg];
  assign m_axis.tvalid = tvalid_int;
  assign m_axis.tlast  = tlast_int;
  assign rd_index      = rd_index_reg;

endmodule

// File: tb/tb_axis_burst_scheduler.sv
// Directed bench for axis_burst_scheduler: single, drop, backpressure, priority, fairness, reset.
module tb_axis_burst_scheduler;

  localparam int N_REQ = 4;
  localparam int DATA_W = 32;
  localparam int BL = 8;
  localparam int IDX_W = $clog2(BL) + 1;

  logic                    aclk;
  logic                    aresetn;
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        grant;
  logic [N_REQ-1:0]        done;
  logic [IDX_W-1:0]        rd_index;
  logic [N_REQ*DATA_W-1:0] rd_data;
  logic                    busy;

  int n_vec = 0;
  int n_bad = 0;

  axis_burst_scheduler_if #(.DATA_W(DATA_W)) axis ();

  axis_burst_scheduler #(
    .N_REQ     (N_REQ),
    .DATA_W    (DATA_W),
    .BURST_LEN (BL),
    .IDX_W     (IDX_W)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .req      (req),
    .grant    (grant),
    .done     (done),
    .rd_index (rd_index),
    .rd_data  (rd_data),
    .m_axis   (axis),
    .busy     (busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Requester buffers: requester i returns (i << 8) | index.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_buf
    assign rd_data[gi*DATA_W +: DATA_W] = DATA_W'(gi * 256) | DATA_W'(rd_index);
  end

  ap_grant_onehot: assert property (@(posedge aclk) disable iff (!aresetn) $onehot0(grant))
    else $error("FAIL assert grant_onehot grant=%b", grant);
  ap_done_onehot: assert property (@(posedge aclk) disable iff (!aresetn) $onehot0(done))
    else $error("FAIL assert done_onehot done=%b", done);
  ap_done_single: assert property (@(posedge aclk) disable iff (!aresetn) (done != 0) |=> (done == 0))
    else $error("FAIL assert done_single done=%b", done);
  ap_tvalid_hold: assert property (@(posedge aclk) disable iff (!aresetn)
      (axis.tvalid && !axis.tready) |=> (axis.tvalid && $stable(axis.tdata) && $stable(axis.tlast)))
    else $error("FAIL assert tvalid_hold");

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Run one burst owned by exp_g; exp_wait>0 checks cycles until tvalid; drop_at>=0 drops req mid-burst.
  task automatic run_burst(input int exp_g, input bit bp_mode, input int drop_at, input int exp_wait);
    int waited;
    int beat;
    int cyc;
    waited = 0;
    while (!axis.tvalid && waited < 20) begin
      step();
      waited++;
    end
    check("tvalid_rise", axis.tvalid, 1);
    if (exp_wait > 0) check("start_gap", waited, exp_wait);
    check("grant_owner", grant, 64'(1 << exp_g));
    check("busy_stream", busy, 1);
    beat = 0;
    cyc = 0;
    while (beat < BL && cyc < 200) begin
      axis.tready = !bp_mode || (cyc % 4 == 0) || (cyc % 4 == 3);
      if (drop_at >= 0 && beat == drop_at) req[exp_g] = 1'b0;
      check("tdata", axis.tdata, 64'(exp_g * 256 + beat));
      check("tlast", axis.tlast, (beat == BL - 1) ? 1 : 0);
      check("rd_index", rd_index, 64'(beat));
      check("tvalid_hold", axis.tvalid, 1);
      if (axis.tready) beat++;
      step();
      cyc++;
    end
    axis.tready = 1'b1;
    check("beats_done", beat, BL);
    check("done_tvalid", axis.tvalid, 0);
    check("done_grant", grant, 0);
    check("done_pulse", done, 64'(1 << exp_g));
    check("done_busy", busy, 1);
    step();
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    aresetn = 1'b0;
    req = '0;
    axis.tready = 1'b1;
    repeat (3) step();
    check("rst_grant", grant, 0);
    check("rst_tvalid", axis.tvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_index", rd_index, 0);
    check("rst_tlast", axis.tlast, 0);

    // Single request right out of reset; first edge after release must not grant.
    aresetn = 1'b1;
    req = 4'b0001;
    step();
    check("early_grant", grant, 0);
    run_burst(0, 1'b0, -1, 0);
    req = '0;

    // Request drop: only req[2], rr_ptr=1; falls after beat 3.
    req = 4'b0100;
    run_burst(2, 1'b0, 3, 1);
    req = '0;

    // Backpressure with tready pattern 1,0,0,1 on requester 1.
    req = 4'b0010;
    run_burst(1, 1'b1, -1, 1);
    req = '0;

    // rr_ptr=2 with req 3 and 0: 3 is first at or after the pointer.
    req = 4'b1001;
    run_burst(3, 1'b0, -1, 1);
    req = '0;

    // Fairness from rr_ptr=0 with all requests held.
    req = 4'b1111;
    run_burst(0, 1'b0, -1, 1);
    run_burst(1, 1'b0, -1, 1);
    run_burst(2, 1'b0, -1, 1);
    run_burst(3, 1'b0, -1, 1);
    run_burst(0, 1'b0, -1, 1);
    req = '0;

    // Reset in the middle of a burst at beat 4.
    req = 4'b0001;
    begin
      int w;
      w = 0;
      while (!axis.tvalid && w < 20) begin
        step();
        w++;
      end
      check("mid_tvalid_rise", axis.tvalid, 1);
      for (int b = 0; b < 4; b++) begin
        check("mid_tdata", axis.tdata, 64'(b));
        step();
      end
      check("mid_index", rd_index, 4);
    end
    aresetn = 1'b0;
    #1;
    check("abort_tvalid", axis.tvalid, 0);
    check("abort_grant", grant, 0);
    check("abort_busy", busy, 0);
    check("abort_index", rd_index, 0);
    check("abort_tlast", axis.tlast, 0);
    for (int c = 0; c < 3; c++) begin
      check("abort_no_done", done, 0);
      step();
    end
    // rr_ptr back at 0, so requester 0 beats requester 1 on restart.
    req = 4'b0011;
    aresetn = 1'b1;
    step();
    check("restart_early_grant", grant, 0);
    run_burst(0, 1'b0, -1, 0);
    req = '0;
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axis_burst_scheduler.md
AXIS_BURST_SCHEDULER -- requirements
Module: axis_burst_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one AXI4-Stream master port (2..8).
REQ-002 Parameter DATA_W, default 32, TDATA width in bits.
REQ-003 Parameter BURST_LEN, default 8, beats per burst (2..256).
REQ-004 Parameter IDX_W, default $clog2(BURST_LEN)+1, width of rd_index.
REQ-005 aclk  in  1  sole clock; all logic is rising-edge.
REQ-006 aresetn  in  1  asynchronous, active-low reset.
REQ-007 req  in  N_REQ  per-requester burst request, level-sensitive.
REQ-008 grant  out  N_REQ  one-hot owner of the stream; all-zero when idle.
REQ-009 done  out  N_REQ  one-cycle pulse on the granted bit after its burst completes.
REQ-010 rd_index  out  IDX_W  beat index presented to all requesters' buffers.
REQ-011 rd_data  in  N_REQ*DATA_W  packed buffer read data, slice i belongs to requester i, combinational from rd_index.
REQ-012 m_axis_tdata  out  DATA_W  stream data.
REQ-013 m_axis_tvalid  out  1  stream valid.
REQ-014 m_axis_tready  in  1  stream ready from the downstream slave.
REQ-015 m_axis_tlast  out  1  high on the final beat of each burst.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, STREAM and DONE.
REQ-018 IDLE: when req is non-zero, the block SHALL pick a winner by round-robin starting at rr_ptr, set grant, clear rd_index to 0, and enter STREAM on the next edge.
REQ-019 Latency: req sampled high in IDLE at edge k SHALL give grant and tvalid high from cycle k+1.
REQ-020 STREAM: tvalid=1; tdata = rd_data slice of the granted requester, selected combinationally; rd_index SHALL change only on a handshake (tvalid and tready).
REQ-021 Each handshake SHALL increment rd_index by 1; tlast = (rd_index == BURST_LEN-1).
REQ-022 A handshake with tlast=1 SHALL move to DONE and drop tvalid, tlast and grant on the next cycle.
REQ-023 DONE lasts one cycle: done[g]=1, rr_ptr <= (g+1) mod N_REQ; the next state is IDLE.
REQ-024 tready low with tvalid high SHALL hold tdata, tlast and rd_index unchanged (AXIS stability); tvalid SHALL never drop before its handshake.
REQ-025 A req deasserted mid-burst SHALL be ignored; the burst runs to BURST_LEN beats.
REQ-026 With multiple reqs in IDLE, the lowest index at or after rr_ptr (wrapping) SHALL win.
REQ-027 The minimum gap between the last beat of one burst and the first beat of the next SHALL be 2 cycles (DONE, IDLE).
REQ-028 A requester SHALL keep rd_data stable while it is granted; the block does not register tdata.

Reset
REQ-029 aresetn low SHALL immediately force state=IDLE, grant=0, done=0, rd_index=0, tvalid=0, tlast=0, busy=0, rr_ptr=0, including mid-burst; an aborted burst SHALL NOT pulse done.
REQ-030 Release of aresetn SHALL be synchronised on the design side; the first grant can occur no earlier than the second edge after release.

Structure
REQ-031 Package axis_sched_pkg SHALL hold the state enum (IDLE/STREAM/DONE) and the default parameter constants.
REQ-032 Round-robin selection SHALL be the sub-module rr_arbiter (inputs req and rr_ptr, output one-hot plus index), purely combinational.

Verification
REQ-033 Single request: req=4'b0001, tready=1, rd_data[0]=index -> tdata 0..7 on 8 consecutive cycles, tlast on the beat with 7, done[0] one cycle later.
REQ-034 Fairness: req=4'b1111 held -> grants in the order 0,1,2,3,0, each exactly 8 beats.
REQ-035 Backpressure: tready toggling 1,0,0,1 -> no beat lost or duplicated, and tdata/tlast are stable while tready=0.
REQ-036 Request drop: req[2] falls after beat 3 -> still 8 beats, then done[2].
REQ-037 Reset mid-burst: aresetn=0 at beat 4 -> tvalid, grant and busy are 0 immediately; no done pulse; after release, req=4'b0001 restarts at rd_index 0.
REQ-038 Assertions: grant is one-hot or zero, tvalid is stable until handshake, done is one-hot and a single cycle.
